button_debouncer: RTL



---
 rtl/button_debouncer_if.sv | 24 ++
 rtl/button_debouncer.sv | 119 +++++++++++
 2 files changed

// File: rtl/button_debouncer_if.sv
// Button debouncer signal bundle: raw button level in, clean level and
// edge strobes out. Clock and reset stay outside as plain ports.
interface button_debouncer_if;
  logic btnIn;
  logic cleanOut;
  logic risePulse;
  logic fallPulse;

  // Driver of the raw button, consumer of the conditioned outputs
  modport master (
    output btnIn,
    input  cleanOut,
    input  risePulse,
    input  fallPulse
  );

  // The debouncer itself
  modport slave (
    input  btnIn,
    output cleanOut,
    output risePulse,
    output fallPulse
  );
endinterface

// File: rtl/button_debouncer.sv
// Button debouncer: a two-flop synchroniser, then a four-state qualify FSM.
// A new level must be seen on the synchronised input for STABLE_COUNT
// consecutive cycles inside a WAIT state before it is committed to cleanOut.
// A commit raises a registered one-cycle rise or fall strobe.
// All outputs are registered, so there is no combinational path from btnIn.
module button_debouncer #(
  parameter int unsigned STABLE_COUNT = 4,   // 1 .. 2**CNT_WIDTH-1
  parameter int unsigned CNT_WIDTH    = 20
) (
  input logic               clk,
  input logic               asyncResetN,
  button_debouncer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  // The count at which the wait commits. The counter never exceeds it,
  // so it cannot wrap.
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(STABLE_COUNT - 1);

  logic                 sync1_q, sync2_q;
  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 clean_q, clean_d;
  logic                 rise_q, rise_d;
  logic                 fall_q, fall_d;

  // Two-flop synchroniser for the asynchronous button level
  always_ff @(posedge clk or negedge asyncResetN) begin
    if (!asyncResetN) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= bus.btnIn;
      sync2_q <= sync1_q;
    end
  end

  // FSM state, stability counter and registered outputs
  always_ff @(posedge clk or negedge asyncResetN) begin
    if (!asyncResetN) begin
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Next state: a WAIT state aborts on any reversion and commits when the
  // count reaches LAST. Strobes default low, so they last exactly one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clean_d = clean_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      IDLE_LOW: begin
        if (sync2_q) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!sync2_q) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
          clean_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE_HIGH: begin
        if (!sync2_q) begin
          state_d = WAIT_LOW;
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        if (sync2_q) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
          clean_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.cleanOut  = clean_q;
  assign bus.risePulse = rise_q;
  assign bus.fallPulse = fall_q;

endmodule
